// File: rtl/scc_pkg.sv
// Shared front-end types and opcodes: queue entry layout and branch predecode helpers.
package scc_pkg;
  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;

  localparam logic [6:0] OPC_BR_UNCOND = 7'b1100000;
  localparam logic [6:0] OPC_BR_COND   = 7'b1100001;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } pf_entry_t;

  function automatic logic is_br_uncond(input logic [INSTR_W-1:0] w);
    return w[31:25] == OPC_BR_UNCOND;
  endfunction

  // 16-bit signed byte offset relative to the branch's own pc; wraps mod 2^32.
  function automatic logic [ADDR_W-1:0] br_target(input logic [ADDR_W-1:0]  pc,
                                                  input logic [INSTR_W-1:0] w);
    return pc + {{16{w[15]}}, w[15:0]};
  endfunction
endpackage

// File: rtl/prefetch_fifo.sv
// In-order prefetch queue of pf_entry_t; flush empties it, push+pop on a full queue is legal.
module prefetch_fifo
  import scc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  pf_entry_t              wdata,
  output pf_entry_t              rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  pf_entry_t     mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign count = wr_ptr - rd_ptr;
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign rdata = mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/instr_prefetch.sv
// Sequential instruction prefetcher feeding IF; redirects flush the queue and squash in-flight reads.
// Define PREFETCH_BRANCH_PREDECODE_EN to follow unconditional branches as their words are queued.
module instr_prefetch
  import scc_pkg::*;
#(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] prefetch,
  output logic [ADDR_W-1:0]  prefetch_pc,
  output logic               prefetch_valid,
  input  logic               fetch_ready,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  logic [ADDR_W-1:0] fetch_addr, resp_pc, int_target;
  logic [OW-1:0]     outstanding, drop_cnt;
  logic [CW-1:0]     count;
  logic              full, empty;
  logic              accept, rsp_take, pop, int_redir;
  pf_entry_t         head, push_entry;

  // A response is kept only when no older-stream words are still owed and no redirect is flushing.
  assign rsp_take   = imem_rvalid && (drop_cnt == '0) && !redirect_valid;
  assign push_entry = '{instr: imem_rdata, pc: resp_pc};

`ifdef PREFETCH_BRANCH_PREDECODE_EN
  assign int_redir  = rsp_take && is_br_uncond(imem_rdata);
  assign int_target = br_target(resp_pc, imem_rdata);
`else
  assign int_redir  = 1'b0;
  assign int_target = resp_pc;
`endif

  // Reserve a queue slot for every read in flight so a response always has room.
  assign imem_req = !reset && !redirect_valid && !int_redir && !full
                 && (outstanding < OW'(MAX_OUTSTANDING))
                 && ((int'(count) + int'(outstanding)) < DEPTH);
  assign imem_addr = fetch_addr;
  assign accept    = imem_req && imem_ready;
  assign pop       = !empty && fetch_ready && !redirect_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_addr  <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + OW'(accept) - OW'(imem_rvalid);
      if (redirect_valid) begin
        fetch_addr <= redirect_pc;
        resp_pc    <= redirect_pc;
        drop_cnt   <= outstanding - OW'(imem_rvalid);
      end else if (int_redir) begin
        // The branch word itself is this cycle's response; everything behind it is stale.
        fetch_addr <= int_target;
        resp_pc    <= int_target;
        drop_cnt   <= outstanding - OW'(1);
      end else begin
        if (accept)   fetch_addr <= fetch_addr + 32'd4;
        if (rsp_take) resp_pc    <= resp_pc + 32'd4;
        if (imem_rvalid && drop_cnt != '0) drop_cnt <= drop_cnt - OW'(1);
      end
    end
  end

  prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rsp_take),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (push_entry),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign prefetch_valid = !empty;
  assign prefetch       = empty ? '0 : head.instr;
  assign prefetch_pc    = empty ? '0 : head.pc;
endmodule

// File: tb/tb_instr_prefetch.sv
// Bench for instr_prefetch: in-order memory model with random latency, architectural-stream scoreboard.
module tb_instr_prefetch;
  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req, imem_ready, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] prefetch, prefetch_pc, redirect_pc;
  logic        prefetch_valid, fetch_ready, redirect_valid;

  always #5 clk = ~clk;

  instr_prefetch #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .prefetch(prefetch), .prefetch_pc(prefetch_pc), .prefetch_valid(prefetch_valid),
    .fetch_ready(fetch_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct {
    logic        fr;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  mreq_t       mq[$];
  logic [31:0] mem_ovr [logic [31:0]];
  int          cyc, last_due, lat_lo, lat_hi, n_tests, n_fail, n_acc, idle;
  logic [31:0] exp_pc, nxt_pc, addr_s, prev_addr;
  logic        acc_s, popd_s, stall_s, prev_stall;

  // Default memory contents never carry a branch opcode in bits [31:25].
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_ovr.exists(a)) return mem_ovr[a];
    return {8'h13, a[25:2]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Drive memory response, then observe combinational outputs before the edge.
  task automatic drive_obs();
    if (!reset && mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mq[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
    end
    #1;
    acc_s   = imem_req && imem_ready;
    stall_s = imem_req && !imem_ready;
    addr_s  = imem_addr;
    popd_s  = prefetch_valid && fetch_ready && !redirect_valid;
    if (prev_stall && !redirect_valid) chk("addr_hold", imem_addr, prev_addr);
    if (mq.size() >= MAXO) chk("max_outstanding", 32'(imem_req), 0);
    if (redirect_valid) chk("req_in_redirect", 32'(imem_req), 0);
    nxt_pc = exp_pc;
    if (popd_s) begin
      chk("pop_pc", prefetch_pc, exp_pc);
      chk("pop_data", prefetch, mem_word(exp_pc));
      nxt_pc = exp_pc + 32'd4;
`ifdef PREFETCH_BRANCH_PREDECODE_EN
      if (prefetch[31:25] == 7'b1100000)
        nxt_pc = exp_pc + {{16{prefetch[15]}}, prefetch[15:0]};
`endif
    end
    if (redirect_valid) nxt_pc = redirect_pc;
  endtask

  task automatic advance();
    int d;
    @(posedge clk);
    if (imem_rvalid) void'(mq.pop_front());
    if (acc_s) begin
      d = cyc + int'($urandom_range(lat_hi, lat_lo));
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      mq.push_back('{addr_s, d});
      n_acc++;
    end
    prev_stall = stall_s;
    prev_addr  = addr_s;
    exp_pc     = nxt_pc;
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      drive_obs();
      advance();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    fetch_ready = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    @(posedge clk); #1;
    chk("rst_req",      32'(imem_req), 0);
    chk("rst_addr",     imem_addr, 0);
    chk("rst_valid",    32'(prefetch_valid), 0);
    chk("rst_prefetch", prefetch, 0);
    chk("rst_pc",       prefetch_pc, 0);
    @(negedge clk);
    reset = 1'b0;
    mq.delete();
    last_due = 0; exp_pc = 32'h0; prev_stall = 1'b0;
  endtask

  initial begin
    vec_t        tv[6];
    logic [31:0] e5[4];
    logic [31:0] e6[6];
    int          k;

    // Latency 1, always ready: one word per cycle once the pipe is primed.
    tv[0] = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h0};
    tv[1] = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h0};
    tv[2] = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h0};
    tv[3] = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h4};
    tv[4] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h8};
    tv[5] = '{1'b1, 1'b1, 32'h14, 1'b1, 32'hC};
`ifdef PREFETCH_BRANCH_PREDECODE_EN
    e5 = '{32'h0, 32'h4, 32'h8, 32'h18};
    e6 = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h8};
`else
    e5 = '{32'h0, 32'h4, 32'h8, 32'hC};
    e6 = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
`endif
    n_tests = 0; n_fail = 0; cyc = 0; n_acc = 0; lat_lo = 1; lat_hi = 1;

    // Streaming from reset.
    do_reset();
    imem_ready = 1'b1;
    foreach (tv[i]) begin
      fetch_ready = tv[i].fr;
      drive_obs();
      chk("tbl_req",   32'(imem_req), 32'(tv[i].exp_req));
      chk("tbl_addr",  imem_addr, tv[i].exp_addr);
      chk("tbl_valid", 32'(prefetch_valid), 32'(tv[i].exp_valid));
      chk("tbl_pc",    prefetch_pc, tv[i].exp_pc);
      advance();
    end

    // Consumer stalled: exactly DEPTH reads, then issue stops.
    do_reset();
    imem_ready = 1'b1; n_acc = 0;
    run(12);
    drive_obs();
    chk("fill_accepts", n_acc, DEPTH);
    chk("fill_req_off", 32'(imem_req), 0);
    chk("fill_valid",   32'(prefetch_valid), 1);
    advance();
    fetch_ready = 1'b1;
    run(10);

    // Latency 3, two reads in flight, redirect to 0x100.
    do_reset();
    lat_lo = 3; lat_hi = 3; imem_ready = 1'b1; fetch_ready = 1'b1;
    run(2);
    chk("inflight_before_redir", mq.size(), 2);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    drive_obs(); advance();
    redirect_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive_obs();
      if (prefetch_valid) break;
      advance();
    end
    chk("redir_first_pc",   prefetch_pc, 32'h100);
    chk("redir_first_data", prefetch, mem_word(32'h100));
    advance();

    // Redirect coincident with pop and response.
    do_reset();
    lat_lo = 1; lat_hi = 1; imem_ready = 1'b1; fetch_ready = 1'b1;
    run(4);
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    drive_obs();
    chk("coinc_setup", {30'h0, prefetch_valid, imem_rvalid}, 32'h3);
    advance();
    redirect_valid = 1'b0;
    drive_obs(); chk("coinc_empty1", 32'(prefetch_valid), 0); advance();
    drive_obs(); chk("coinc_empty2", 32'(prefetch_valid), 0); advance();
    run(4);

    // Forward branch word at 0x8 (offset +0x10).
    mem_ovr[32'h8] = 32'hC000_0010;
    do_reset();
    imem_ready = 1'b1;
    run(12);
    fetch_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_obs();
      chk("br_fwd_seq", prefetch_pc, e5[i]);
      advance();
    end
    mem_ovr.delete();

    // Backward branch word at 0x10 (offset -8).
    mem_ovr[32'h10] = 32'hC000_FFF8;
    do_reset();
    imem_ready = 1'b1; fetch_ready = 1'b1; k = 0;
    for (int i = 0; i < 30 && k < 6; i++) begin
      drive_obs();
      if (popd_s) begin
        chk("br_back_seq", prefetch_pc, e6[k]);
        k++;
      end
      advance();
    end
    chk("br_back_count", k, 6);
    mem_ovr.delete();

    // Random traffic: ready stalls, variable latency, redirects (incl. wrap), occasional reset.
    do_reset();
    lat_lo = 1; lat_hi = 4; idle = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom % 700 == 0) begin
        do_reset();
        idle = 0;
      end
      fetch_ready    = ($urandom % 3) != 0;
      imem_ready     = ($urandom % 4) != 0;
      redirect_valid = ($urandom % 40) == 0;
      redirect_pc    = ($urandom % 4 == 0) ? 32'hFFFF_FFF0
                                           : 32'h1000 + (32'($urandom_range(1023, 0)) << 2);
      drive_obs();
      if (popd_s) idle = 0;
      else if (fetch_ready && !redirect_valid) idle++;
      advance();
      if (idle > 60) begin
        chk("liveness", 0, 1);
        break;
      end
    end
    redirect_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
